// File: rtl/game_round_timer_pkg.sv
// ---------------------------------------------------------------------------
// game_round_timer_pkg
// Shared game constants and types. The round FSM, the HUD overlay and the
// multiplayer link all import this package so they agree on round length,
// magazine size, reload time and the score that ends a round.
// ---------------------------------------------------------------------------
package game_round_timer_pkg;

    localparam int unsigned GAME_CLK_FREQ_HZ  = 65_000_000;
    localparam int unsigned GAME_ROUND_TIME_S = 60;
    localparam int unsigned GAME_MAGAZINE     = 6;
    localparam int unsigned GAME_RELOAD_S     = 2;
    localparam int unsigned GAME_SCORE_TARGET = 50;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        RELOAD,
        FINISHED
    } round_state_t;

    // Decrement that stops at zero instead of wrapping.
    function automatic logic [7:0] sat_dec8(input logic [7:0] value);
        return (value == 8'd0) ? 8'd0 : value - 8'd1;
    endfunction

    // Increment that stops at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? 8'hFF : value + 8'd1;
    endfunction

endpackage

// File: rtl/game_round_timer_tick_prescaler.sv
// ---------------------------------------------------------------------------
// game_round_timer_tick_prescaler
// Divides the system clock down to a one-cycle sec_tick every DIVIDE enabled
// cycles. The count holds while en is low and returns to zero on clr.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   en        in   count enable
//   clr       in   synchronous clear (wins over en)
//   sec_tick  out  high in the enabled cycle where the count wraps
// ---------------------------------------------------------------------------
module game_round_timer_tick_prescaler #(
    parameter int unsigned DIVIDE = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic sec_tick
);

    localparam int unsigned CNT_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DIVIDE - 1);

    logic [CNT_W-1:0] count;

    // The tick is combinational so the round logic sees it in the same cycle
    // the counter wraps, keeping a full second exactly DIVIDE enabled cycles.
    assign sec_tick = en && (count == TERMINAL);

    // Counter register: clear has priority, otherwise count only when enabled.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            if (count == TERMINAL) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_round_timer.sv
// ---------------------------------------------------------------------------
// game_round_timer
// Per-round bookkeeping for the duck game: seconds remaining, magazine and
// reload handling, score, and the game_finished level. Armed by
// game_enable_posedge, runs while game_enable is high, and freezes its
// counters for display once the round ends or the FSM leaves early.
//
// Ports:
//   clk                  in   system clock
//   rst                  in   synchronous, active-high reset
//   game_enable          in   high while the game FSM is in GAME_RUNNING
//   game_enable_posedge  in   one-cycle pulse at round start
//   left_mouse           in   raw left-button level (already synchronised)
//   duck_hit             in   high while the cursor overlaps a live duck
//   time_left            out  seconds remaining
//   shots_left           out  rounds left in the magazine
//   reloading            out  high during the reload window
//   score                out  hits this round
//   shot_fired           out  one-cycle pulse per accepted shot
//   hit_registered       out  one-cycle pulse per accepted hit
//   game_finished        out  high once the round has ended
// ---------------------------------------------------------------------------
module game_round_timer
    import game_round_timer_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = GAME_CLK_FREQ_HZ,
    parameter int unsigned ROUND_TIME_S = GAME_ROUND_TIME_S,
    parameter int unsigned MAGAZINE     = GAME_MAGAZINE,
    parameter int unsigned RELOAD_S     = GAME_RELOAD_S,
    parameter int unsigned SCORE_TARGET = GAME_SCORE_TARGET
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_enable,
    input  logic       game_enable_posedge,
    input  logic       left_mouse,
    input  logic       duck_hit,
    output logic [7:0] time_left,
    output logic [3:0] shots_left,
    output logic       reloading,
    output logic [7:0] score,
    output logic       shot_fired,
    output logic       hit_registered,
    output logic       game_finished
);

    localparam int unsigned RELOAD_W = $clog2(RELOAD_S + 1);

    round_state_t        state, state_next;
    logic [7:0]          time_left_next, score_next;
    logic [3:0]          shots_left_next;
    logic                reloading_next, shot_fired_next;
    logic                hit_registered_next, game_finished_next;
    logic [RELOAD_W-1:0] reload_cnt, reload_cnt_next;
    logic                left_mouse_prev;

    logic                sec_tick, presc_en;
    logic                shot_req, shot_ok, hit_ok;
    logic                time_out, target_hit;
    logic [7:0]          score_inc;

    // Seconds only elapse while a round is actually being played; the
    // prescaler freezes in IDLE/FINISHED and restarts at every round load.
    assign presc_en = ((state == RUNNING) || (state == RELOAD)) && game_enable;

    game_round_timer_tick_prescaler #(
        .DIVIDE (CLK_FREQ_HZ)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (presc_en),
        .clr      (game_enable_posedge),
        .sec_tick (sec_tick)
    );

    // Event decode: a shot is a rising edge of the button, and it only counts
    // while running with rounds left. Finishing is detected one step ahead
    // so game_finished rises in the same cycle time or score hit the limit.
    always_comb begin
        shot_req   = left_mouse & ~left_mouse_prev;
        shot_ok    = (state == RUNNING) && game_enable && shot_req && (shots_left != 4'd0);
        hit_ok     = shot_ok && duck_hit;
        score_inc  = sat_inc8(score);
        time_out   = sec_tick && (time_left == 8'd1);
        target_hit = hit_ok && (score_inc == 8'(SCORE_TARGET));
    end

    // Next-state and next-output logic. A round load overrides everything
    // else; leaving GAME_RUNNING early drops to IDLE with counters frozen.
    // Finishing wins over entering reload when both happen in one cycle.
    always_comb begin
        state_next          = state;
        time_left_next      = time_left;
        shots_left_next     = shots_left;
        score_next          = score;
        reloading_next      = reloading;
        reload_cnt_next     = reload_cnt;
        game_finished_next  = game_finished;
        shot_fired_next     = 1'b0;
        hit_registered_next = 1'b0;

        if (game_enable_posedge) begin
            state_next         = RUNNING;
            time_left_next     = 8'(ROUND_TIME_S);
            shots_left_next    = 4'(MAGAZINE);
            score_next         = 8'd0;
            reloading_next     = 1'b0;
            reload_cnt_next    = '0;
            game_finished_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    game_finished_next = 1'b0;
                    reloading_next     = 1'b0;
                end

                RUNNING: begin
                    if (!game_enable) begin
                        state_next = IDLE;
                    end else begin
                        if (sec_tick) begin
                            time_left_next = sat_dec8(time_left);
                        end
                        if (shot_ok) begin
                            shots_left_next = shots_left - 4'd1;
                            shot_fired_next = 1'b1;
                        end
                        if (hit_ok) begin
                            score_next          = score_inc;
                            hit_registered_next = 1'b1;
                        end
                        if (time_out || target_hit) begin
                            state_next         = FINISHED;
                            game_finished_next = 1'b1;
                            reloading_next     = 1'b0;
                        end else if (shot_ok && (shots_left == 4'd1)) begin
                            state_next      = RELOAD;
                            reload_cnt_next = RELOAD_W'(RELOAD_S);
                            reloading_next  = 1'b1;
                        end
                    end
                end

                RELOAD: begin
                    if (!game_enable) begin
                        state_next     = IDLE;
                        reloading_next = 1'b0;
                    end else if (sec_tick) begin
                        time_left_next = sat_dec8(time_left);
                        if (time_out) begin
                            state_next         = FINISHED;
                            game_finished_next = 1'b1;
                            reloading_next     = 1'b0;
                        end else if (reload_cnt <= RELOAD_W'(1)) begin
                            state_next      = RUNNING;
                            shots_left_next = 4'(MAGAZINE);
                            reloading_next  = 1'b0;
                            reload_cnt_next = '0;
                        end else begin
                            reload_cnt_next = reload_cnt - RELOAD_W'(1);
                        end
                    end
                end

                FINISHED: begin
                    game_finished_next = 1'b1;
                    reloading_next     = 1'b0;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            time_left       <= 8'd0;
            shots_left      <= 4'd0;
            score           <= 8'd0;
            reloading       <= 1'b0;
            reload_cnt      <= '0;
            shot_fired      <= 1'b0;
            hit_registered  <= 1'b0;
            game_finished   <= 1'b0;
            left_mouse_prev <= 1'b0;
        end else begin
            state           <= state_next;
            time_left       <= time_left_next;
            shots_left      <= shots_left_next;
            score           <= score_next;
            reloading       <= reloading_next;
            reload_cnt      <= reload_cnt_next;
            shot_fired      <= shot_fired_next;
            hit_registered  <= hit_registered_next;
            game_finished   <= game_finished_next;
            left_mouse_prev <= left_mouse;
        end
    end

endmodule

// File: tb/tb_game_round_timer.sv
// ---------------------------------------------------------------------------
// tb_game_round_timer
// Directed bench for game_round_timer with a 10-cycle second, 3 s rounds,
// a 2-shot magazine, 1 s reload and a score target of 3. Inputs change 1 time
// unit after each rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_game_round_timer;

    localparam int unsigned CLK_FREQ_HZ  = 10;
    localparam int unsigned ROUND_TIME_S = 3;
    localparam int unsigned MAGAZINE     = 2;
    localparam int unsigned RELOAD_S     = 1;
    localparam int unsigned SCORE_TARGET = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_enable = 1'b0;
    logic       game_enable_posedge = 1'b0;
    logic       left_mouse = 1'b0;
    logic       duck_hit = 1'b0;
    logic [7:0] time_left;
    logic [3:0] shots_left;
    logic       reloading;
    logic [7:0] score;
    logic       shot_fired;
    logic       hit_registered;
    logic       game_finished;

    int testsRun    = 0;
    int testsFailed = 0;

    game_round_timer #(
        .CLK_FREQ_HZ  (CLK_FREQ_HZ),
        .ROUND_TIME_S (ROUND_TIME_S),
        .MAGAZINE     (MAGAZINE),
        .RELOAD_S     (RELOAD_S),
        .SCORE_TARGET (SCORE_TARGET)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .game_enable         (game_enable),
        .game_enable_posedge (game_enable_posedge),
        .left_mouse          (left_mouse),
        .duck_hit            (duck_hit),
        .time_left           (time_left),
        .shots_left          (shots_left),
        .reloading           (reloading),
        .score               (score),
        .shot_fired          (shot_fired),
        .hit_registered      (hit_registered),
        .game_finished       (game_finished)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and land 1 unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive the mouse/duck inputs for exactly one clock edge.
    task automatic applyStimulus(input logic lm, input logic dh);
        left_mouse = lm;
        duck_hit   = dh;
        tick(1);
    endtask

    // Pulse game_enable_posedge with game_enable high; load happens on this edge.
    task automatic startRound();
        game_enable         = 1'b1;
        game_enable_posedge = 1'b1;
        left_mouse          = 1'b0;
        duck_hit            = 1'b0;
        tick(1);
        game_enable_posedge = 1'b0;
    endtask

    // One click (press edge then release edge) with checks on the press edge.
    task automatic clickAndCheck(input string tag, input logic dh,
                                 input logic expFired, input logic expHit,
                                 input int expShots, input int expScore);
        applyStimulus(1'b1, dh);
        checkOutput({tag, "_shot_fired"}, shot_fired, expFired);
        checkOutput({tag, "_hit_registered"}, hit_registered, expHit);
        checkOutput({tag, "_shots_left"}, shots_left, expShots);
        checkOutput({tag, "_score"}, score, expScore);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_time_left"}, time_left, 0);
        checkOutput({tag, "_shots_left"}, shots_left, 0);
        checkOutput({tag, "_reloading"}, reloading, 0);
        checkOutput({tag, "_score"}, score, 0);
        checkOutput({tag, "_shot_fired"}, shot_fired, 0);
        checkOutput({tag, "_hit_registered"}, hit_registered, 0);
        checkOutput({tag, "_game_finished"}, game_finished, 0);
    endtask

    initial begin
        int pulses;

        // Reset state
        rst = 1'b1;
        tick(2);
        checkAllZero("reset");
        rst = 1'b0;

        // Plain countdown, no clicks: 3 -> 2 -> 1 -> 0 at 10/20/30 cycles
        startRound();
        checkOutput("load_time", time_left, 3);
        checkOutput("load_shots", shots_left, 2);
        checkOutput("load_finished", game_finished, 0);
        tick(9);
        checkOutput("cd_t9", time_left, 3);
        tick(1);
        checkOutput("cd_t10", time_left, 2);
        tick(10);
        checkOutput("cd_t20", time_left, 1);
        tick(9);
        checkOutput("cd_t29_time", time_left, 1);
        checkOutput("cd_t29_finished", game_finished, 0);
        tick(1);
        checkOutput("cd_t30_time", time_left, 0);
        checkOutput("cd_t30_finished", game_finished, 1);
        checkOutput("cd_t30_shots", shots_left, 2);
        checkOutput("cd_t30_score", score, 0);
        tick(15);
        checkOutput("cd_frozen_time", time_left, 0);
        checkOutput("cd_frozen_finished", game_finished, 1);

        // Restart from FINISHED, then two hits empty the magazine into reload
        startRound();
        checkOutput("restart_time", time_left, 3);
        checkOutput("restart_shots", shots_left, 2);
        checkOutput("restart_score", score, 0);
        checkOutput("restart_finished", game_finished, 0);
        clickAndCheck("hit1", 1'b1, 1'b1, 1'b1, 1, 1);
        checkOutput("hit1_pulse_gone", shot_fired, 0);
        clickAndCheck("hit2", 1'b1, 1'b1, 1'b1, 0, 2);
        checkOutput("hit2_reloading", reloading, 1);
        clickAndCheck("reload_click", 1'b1, 1'b0, 1'b0, 0, 2);
        tick(3);
        checkOutput("reload_t9", reloading, 1);
        tick(1);
        checkOutput("reload_done_shots", shots_left, 2);
        checkOutput("reload_done_reloading", reloading, 0);
        checkOutput("reload_done_time", time_left, 2);

        // Third hit reaches the target and ends the round immediately
        clickAndCheck("hit3", 1'b1, 1'b1, 1'b1, 1, 3);
        checkOutput("hit3_finished", game_finished, 0 + 1);
        clickAndCheck("after_finish_click", 1'b1, 1'b0, 1'b0, 1, 3);
        tick(20);
        checkOutput("after_finish_time", time_left, 2);
        checkOutput("after_finish_finished", game_finished, 1);

        // game_enable dropping mid-round parks in IDLE with frozen counters
        startRound();
        tick(5);
        game_enable = 1'b0;
        tick(21);
        checkOutput("idle_time", time_left, 3);
        checkOutput("idle_finished", game_finished, 0);
        clickAndCheck("idle_click", 1'b1, 1'b0, 1'b0, 2, 0);

        // Button held for 50 cycles yields a single shot
        startRound();
        pulses = 0;
        left_mouse = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (shot_fired) pulses++;
        end
        left_mouse = 1'b0;
        tick(1);
        checkOutput("hold_pulses", pulses, 1);
        checkOutput("hold_shots", shots_left, 1);

        // Hit lands on the same edge as the final second tick
        startRound();
        tick(29);
        checkOutput("last_tick_pre_time", time_left, 1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("last_tick_score", score, 1);
        checkOutput("last_tick_time", time_left, 0);
        checkOutput("last_tick_finished", game_finished, 1);
        checkOutput("last_tick_hit", hit_registered, 1);
        applyStimulus(1'b0, 1'b0);
        checkOutput("last_tick_hold_finished", game_finished, 1);
        checkOutput("last_tick_hold_score", score, 1);
        checkOutput("last_tick_hold_hit", hit_registered, 0);

        // Reset asserted while reloading
        startRound();
        clickAndCheck("rr_hit1", 1'b1, 1'b1, 1'b1, 1, 1);
        clickAndCheck("rr_hit2", 1'b1, 1'b1, 1'b1, 0, 2);
        checkOutput("rr_reloading", reloading, 1);
        rst = 1'b1;
        tick(1);
        checkAllZero("rr_reset");
        rst = 1'b0;
        tick(3);
        checkOutput("rr_after_time", time_left, 0);
        checkOutput("rr_after_finished", game_finished, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/game_round_timer.md
Name: game_round_timer

Overview:
Upstream feeder of the game control FSM: owns the per-round clock, ammunition and score bookkeeping, and raises game_finished when the round ends. It is armed by game_enable_posedge, runs while game_enable is high, and freezes its counters for display once the round ends. Its outputs also drive the HUD/text overlay and the multiplayer link.

Parameters:
CLK_FREQ_HZ, 65_000_000, system clock frequency; one second equals CLK_FREQ_HZ cycles.
ROUND_TIME_S, 60, round length in seconds; must be in 1..255.
MAGAZINE, 6, shots per magazine; must be in 1..15.
RELOAD_S, 2, seconds of enforced reload after the magazine empties; must be ≥1.
SCORE_TARGET, 50, score that ends the round early; must be in 1..255.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
game_enable  in  1  level, high while the FSM is in GAME_RUNNING
game_enable_posedge  in  1  one-cycle pulse at round start
left_mouse  in  1  raw left-button level, already synchronised to clk
duck_hit  in  1  level, high while the cursor overlaps a live duck
time_left  out  8  seconds remaining
shots_left  out  4  rounds left in the magazine
reloading  out  1  high during the reload window
score  out  8  hits this round
shot_fired  out  1  one-cycle pulse per accepted shot
hit_registered  out  1  one-cycle pulse per accepted hit
game_finished  out  1  level, high once the round has ended

Behaviour:
- Reset values: time_left=0, shots_left=0, reloading=0, score=0, shot_fired=0, hit_registered=0, game_finished=0, state=IDLE, prescaler=0, left_mouse_prev=0.
- All outputs are registered.
- States: IDLE, RUNNING, RELOAD, FINISHED. game_enable_posedge from any state loads the round and forces RUNNING on the next cycle; this is the highest-priority event.
- Round load: time_left=ROUND_TIME_S, shots_left=MAGAZINE, score=0, prescaler=0, game_finished=0, reloading=0.
- Prescaler: counts 0..CLK_FREQ_HZ-1 in RUNNING and RELOAD only. On terminal count it wraps to 0 and issues sec_tick.
- sec_tick decrements time_left, saturating at 0. The prescaler holds its value in IDLE and FINISHED.
- Shot detection: shot_req = left_mouse & ~left_mouse_prev. left_mouse_prev updates every cycle in every state.
- RUNNING with shot_req and shots_left>0:
  - shots_left decrements and shot_fired pulses in the following cycle.
  - If duck_hit is also high in the same cycle, score increments (saturating at 255) and hit_registered pulses in that same cycle.
- shot_req in RELOAD, IDLE or FINISHED is ignored: no pulse and no counter change.
- RUNNING → RELOAD when an accepted shot takes shots_left to 0. A reload counter loads RELOAD_S and reloading goes to 1.
- RELOAD:
  - The reload counter decrements on sec_tick.
  - When it reaches 0: shots_left=MAGAZINE, reloading=0, state → RUNNING.
  - The first reload tick can therefore be shorter than one full second; this is accepted.
- → FINISHED from RUNNING or RELOAD when either condition holds:
  - time_left==1 and sec_tick (time_left becomes 0 in the same cycle), or
  - an accepted hit makes score==SCORE_TARGET.
- Simultaneous events: if a hit and the final sec_tick fall in the same cycle, the hit is counted and FINISHED is entered once.
- FINISHED: game_finished=1 (level), all counters frozen, reloading=0. Exit only on rst or game_enable_posedge.
- game_enable falling while RUNNING or RELOAD (FSM left early): go to IDLE and freeze the counters; game_finished stays 0.
- In IDLE, game_finished=0 and the counters hold their last values for display.
- rst mid-round returns all state to reset values on the next edge.
- Widths: the prescaler is $clog2(CLK_FREQ_HZ) bits. All comparisons are unsigned.

Decomposition:
- Add the ROUND_TIME_S, MAGAZINE, RELOAD_S and SCORE_TARGET defaults to the shared game package so the FSM, HUD and link share one source.
- Add a round_state_t enum (IDLE, RUNNING, RELOAD, FINISHED) to the same package.
- One natural sub-module, tick_prescaler: parameterised divider with an enable and a synchronous clear, producing sec_tick.

Test Plan (benches use CLK_FREQ_HZ=10, ROUND_TIME_S=3, MAGAZINE=2, RELOAD_S=1, SCORE_TARGET=3):
- rst, then game_enable=1 with a game_enable_posedge pulse, no clicks → time_left goes 3,2,1,0 at cycles 10, 20, 30 after the load; game_finished=1 in the cycle time_left reaches 0; shots_left=2 and score=0 throughout.
- Two clicks with duck_hit=1 → score=2, shots_left=0, hit_registered pulses twice, reloading=1. A third click during RELOAD is ignored. After one sec_tick, shots_left=2 and reloading=0.
- Three accepted hits spanning a reload, all within time → score=3 and game_finished=1 in the same cycle as the third hit; later clicks and ticks change nothing.
- left_mouse held high for 50 cycles → exactly one shot_fired pulse.
- Hit on the same cycle as the final sec_tick → score increments, game_finished=1, single entry into FINISHED.
- rst asserted mid-RELOAD → next cycle all outputs at reset values. Separately, a game_enable_posedge from FINISHED → counters reload to 3/2/0 and game_finished=0.
